// File: rtl/serial_bit_feeder_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared declarations for the serial bit feeder: the shifter state
//   encoding, counter/pointer width helpers, and the widths for the
//   default configuration (WIDTH=8, DEPTH=2).
//
//   Optional feature macro: SERIAL_PARITY_EN (PAR state is only entered
//   when this macro is defined).
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;

  // Widths for the default build
  localparam int CNT_W = $clog2(DEF_WIDTH);
  localparam int PTR_W = $clog2(DEF_DEPTH) + 1;

  // Bit counter width for an arbitrary word width (holds 0..WIDTH-1)
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // FIFO pointer width: one extra wrap bit to tell full from empty
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder_if
//   Groups the word-input handshake and the serial output of the feeder.
//   master : word producer / serial consumer (testbench or upstream logic)
//   slave  : the serial_bit_feeder itself
//   Signals:
//     in_valid  producer has a word on in_data
//     in_ready  feeder can take a word (registered, = !fifo_full)
//     in_data   parallel word, WIDTH bits
//     bit_out   serial bit, 0 whenever bit_valid is low
//     bit_valid bit_out carries data
//     sof       first (MSB) bit of a word
//     busy      FIFO non-empty or a word still on the line
// ---------------------------------------------------------------------------
interface serial_bit_feeder_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             bit_out;
  logic             bit_valid;
  logic             sof;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, bit_out, bit_valid, sof, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, bit_out, bit_valid, sof, busy
  );

endinterface

// File: rtl/serial_bit_feeder_word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo
//   Small synchronous FIFO of parallel words in front of the shifter.
//   Pointers carry one extra wrap bit and wrap modulo 2*DEPTH; full and
//   empty are decoded from the pointer MSBs. Push is ignored when full and
//   pop is ignored when empty, so a push in a full cycle is refused even
//   if a pop happens on the same edge.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     i_push      write i_data (honoured only when not full)
//     i_data      word to write
//     i_pop       drop head entry (honoured only when not empty)
//     o_data      head entry (valid when o_empty is low)
//     o_full      FIFO holds DEPTH words
//     o_empty     FIFO holds no words
// ---------------------------------------------------------------------------
module word_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int P_W = ptr_width(DEPTH);
  localparam int A_W = P_W - 1;

  logic [P_W-1:0]   r_wr_ptr;
  logic [P_W-1:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[P_W-1] != r_rd_ptr[P_W-1]) &&
                   (r_wr_ptr[A_W-1:0] == r_rd_ptr[A_W-1:0]);

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;

  assign o_data = r_mem[r_rd_ptr[A_W-1:0]];

  // Pointer registers; push and pop on the same edge leave occupancy unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[A_W-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
//   Takes parallel words over a valid/ready handshake, buffers them in a
//   word_fifo and shifts them out MSB-first, one bit per clock. Words are
//   sent back-to-back with no idle bubble while the FIFO has data.
//   Parameters: WIDTH (2..32) bits per word, DEPTH (power of two, >=2).
//   Ports:
//     clk    single clock, posedge
//     rst_n  asynchronous active-low reset
//     bus    serial_bit_feeder_if.slave (in_valid/in_ready/in_data,
//            bit_out/bit_valid/sof/busy)
//   Build option: define SERIAL_PARITY_EN to append an even-parity bit
//   (XOR of the word) after each LSB, in a dedicated PAR state.
// ---------------------------------------------------------------------------
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
)
(
  input  logic               clk,
  input  logic               rst_n,
  serial_bit_feeder_if.slave bus
);

  localparam int BIT_CNT_W = cnt_width(WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_load;
  logic [WIDTH-1:0]     w_head;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_shreg;
  logic [WIDTH-1:0]     w_next_shreg;
  logic [BIT_CNT_W-1:0] r_bitcnt;
  logic [BIT_CNT_W-1:0] w_next_bitcnt;

  logic                 r_bit_out;
  logic                 r_bit_valid;
  logic                 r_sof;
  logic                 w_bit_out_d;
  logic                 w_bit_valid_d;
  logic                 w_sof_d;

`ifdef SERIAL_PARITY_EN
  logic                 r_parity;
`endif

  // in_ready depends only on registered FIFO pointers, never on the FSM
  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid && !w_full;

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Shifter state, shift register, bit counter and (optionally) the parity
  // of the word currently on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
`ifdef SERIAL_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_next_state;
      r_shreg  <= w_next_shreg;
      r_bitcnt <= w_next_bitcnt;
`ifdef SERIAL_PARITY_EN
      if (w_load) begin
        r_parity <= ^w_head;
      end
`endif
    end
  end

  // Next-state logic. Any state that finishes a word reloads from the FIFO
  // on the same edge when data is waiting, so consecutive words abut.
  always_comb begin
    w_next_state  = r_state;
    w_next_shreg  = r_shreg;
    w_next_bitcnt = r_bitcnt;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        w_next_shreg  = {r_shreg[WIDTH-2:0], 1'b0};
        w_next_bitcnt = r_bitcnt - 1'b1;
        if (r_bitcnt == '0) begin
`ifdef SERIAL_PARITY_EN
          w_next_state = PAR;
`else
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      PAR: begin
        if (!w_empty) begin
          w_load = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (w_load) begin
      w_next_state  = SHIFT;
      w_next_shreg  = w_head;
      w_next_bitcnt = LAST_BIT;
    end
  end

  assign w_pop = w_load;

  // Line values decoded from the current shifter state
  always_comb begin
    w_bit_out_d   = 1'b0;
    w_bit_valid_d = 1'b0;
    w_sof_d       = 1'b0;
    if (r_state == SHIFT) begin
      w_bit_out_d   = r_shreg[WIDTH-1];
      w_bit_valid_d = 1'b1;
      w_sof_d       = (r_bitcnt == LAST_BIT);
    end
`ifdef SERIAL_PARITY_EN
    if (r_state == PAR) begin
      w_bit_out_d   = r_parity;
      w_bit_valid_d = 1'b1;
    end
`endif
  end

  // Output flops: the line is driven purely from registers, one cycle after
  // the shifter state, and is cleared at once by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_sof       <= 1'b0;
    end else begin
      r_bit_out   <= w_bit_out_d;
      r_bit_valid <= w_bit_valid_d;
      r_sof       <= w_sof_d;
    end
  end

  assign bus.bit_out   = r_bit_out;
  assign bus.bit_valid = r_bit_valid;
  assign bus.sof       = r_sof;
  // The final bit is still on the line one cycle after the FSM returns to IDLE
  assign bus.busy      = !w_empty || (r_state != IDLE) || r_bit_valid;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_feeder
//   Self-checking bench for serial_bit_feeder (WIDTH=8, DEPTH=2).
//   Words are pushed through applyStimulus, which queues the expected serial
//   bits at the moment a word is accepted; a monitor pops and compares one
//   entry per valid bit. A small overlapping 1010 detector watches the data
//   bits. Honours SERIAL_PARITY_EN like the design.
// ---------------------------------------------------------------------------
module tb_serial_bit_feeder;
  import serial_pkg::*;

`ifdef SERIAL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int WORD_BITS = 8 + PAR_BITS;

  typedef struct {
    logic bitv;
    logic sof;
    logic isPar;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] expBits;
    int         exp1010;
  } vec_t;

  logic clk;
  logic rst_n;

  exp_t sbQueue[$];
  int   compareCount = 0;
  int   failCount    = 0;
  int   recvCount    = 0;
  int   runStarts    = 0;
  int   detCount     = 0;
  logic [3:0] detHist = 4'b0000;
  logic prevValid    = 1'b0;
  logic sawNotReady  = 1'b0;

  serial_bit_feeder_if #(.WIDTH(8)) bus ();

  serial_bit_feeder #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges despite the bounded waits
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a word and hold it until accepted; expected bits are queued at
  // acceptance. Returns on the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] expBits);
    bit   accepted;
    exp_t e;
    accepted     = 1'b0;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      if (bus.in_ready) begin
        for (int b = 7; b >= 0; b--) begin
          e.bitv  = expBits[b];
          e.sof   = (b == 7);
          e.isPar = 1'b0;
          sbQueue.push_back(e);
        end
`ifdef SERIAL_PARITY_EN
        e.bitv  = ^expBits;
        e.sof   = 1'b0;
        e.isPar = 1'b1;
        sbQueue.push_back(e);
`endif
        accepted = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checkOutput("acceptTimeout", int'(bus.in_ready), 1);
    end
  endtask

  // Wait (bounded) until the block is idle and every expected bit was seen
  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && sbQueue.size() == 0) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checkOutput("idleTimeout", int'(bus.busy), 0);
    end
    checkOutput("sbDrained", sbQueue.size(), 0);
  endtask

  task automatic clearDetector();
    detCount = 0;
    detHist  = 4'b0000;
  endtask

  // Monitor: one scoreboard pop per valid bit, zero line when not valid
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.bit_valid) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpectedBit", int'(bus.bit_valid), 0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("bitOut", int'(bus.bit_out), int'(e.bitv));
          checkOutput("sof", int'(bus.sof), int'(e.sof));
          recvCount++;
          if (!e.isPar) begin
            detHist = {detHist[2:0], bus.bit_out};
            if (detHist == 4'b1010) begin
              detCount++;
            end
          end
        end
        if (!prevValid) begin
          runStarts++;
        end
      end else if (bus.bit_out !== 1'b0 || bus.sof !== 1'b0) begin
        checkOutput("idleLine", int'({bus.bit_out, bus.sof}), 0);
      end
      if (!bus.in_ready) begin
        sawNotReady = 1'b1;
      end
      prevValid = bus.bit_valid;
    end else begin
      prevValid = 1'b0;
    end
  end

  initial begin
    vec_t vecs[8];
    int   base;
    int   baseRuns;
    bit   found;

    vecs[0] = '{8'hA5, 8'hA5, 1};
    vecs[1] = '{8'h3C, 8'h3C, 0};
    vecs[2] = '{8'h5A, 8'h5A, 1};
    vecs[3] = '{8'h81, 8'h81, 0};
    vecs[4] = '{8'hAA, 8'hAA, 3};
    vecs[5] = '{8'h00, 8'h00, 0};
    vecs[6] = '{8'hFF, 8'hFF, 0};
    vecs[7] = '{8'h50, 8'h50, 1};

    $display("[TB] start: CNT_W=%0d PTR_W=%0d parity=%0d", CNT_W, PTR_W, PAR_BITS);

    // Reset and idle state
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBitValid", int'(bus.bit_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstInReady", int'(bus.in_ready), 1);
    checkOutput("rstBitValid2", int'(bus.bit_valid), 0);
    checkOutput("rstBitOut", int'(bus.bit_out), 0);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstSof", int'(bus.sof), 0);

    // Single word: first bit appears two edges after acceptance
    clearDetector();
    applyStimulus(8'hA5, 8'hA5);
    #1;
    checkOutput("lat0Valid", int'(bus.bit_valid), 0);
    checkOutput("lat0Busy", int'(bus.busy), 1);
    @(negedge clk);
    #1;
    checkOutput("lat1Valid", int'(bus.bit_valid), 0);
    @(negedge clk);
    #1;
    checkOutput("lat2Valid", int'(bus.bit_valid), 1);
    checkOutput("lat2Sof", int'(bus.sof), 1);
    checkOutput("lat2Bit", int'(bus.bit_out), 1);
    waitIdle();
    checkOutput("a5Det", detCount, 1);

    // Table of isolated words
    for (int i = 0; i < 8; i++) begin
      clearDetector();
      base = recvCount;
      applyStimulus(vecs[i].data, vecs[i].expBits);
      waitIdle();
      checkOutput($sformatf("vec%0dBits", i), recvCount - base, WORD_BITS);
      checkOutput($sformatf("vec%0dDet", i), detCount, vecs[i].exp1010);
    end

    // Back-to-back words: one contiguous run, three 1010 hits
    clearDetector();
    base     = recvCount;
    baseRuns = runStarts;
    applyStimulus(8'hAA, 8'hAA);
    applyStimulus(8'h0F, 8'h0F);
    waitIdle();
    checkOutput("b2bBits", recvCount - base, 2 * WORD_BITS);
    checkOutput("b2bRuns", runStarts - baseRuns, 1);
    checkOutput("b2bDet", detCount, 3);

    // Four words while shifting: FIFO fills, in_ready drops, order kept
    sawNotReady = 1'b0;
    base        = recvCount;
    applyStimulus(8'h11, 8'h11);
    applyStimulus(8'h22, 8'h22);
    applyStimulus(8'h33, 8'h33);
    applyStimulus(8'h44, 8'h44);
    waitIdle();
    checkOutput("fullSeen", int'(sawNotReady), 1);
    checkOutput("fullBits", recvCount - base, 4 * WORD_BITS);

    // Reset in the middle of a word: line drops at once, nothing trails
    base  = recvCount;
    found = 1'b0;
    applyStimulus(8'hFF, 8'hFF);
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      #1;
      if (recvCount - base == 3) begin
        found = 1'b1;
      end
    end
    checkOutput("midFound", int'(found), 1);
    @(posedge clk);
    #2;
    checkOutput("midBitBefore", int'(bus.bit_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", int'(bus.bit_valid), 0);
    checkOutput("midRstBit", int'(bus.bit_out), 0);
    checkOutput("midRstBusy", int'(bus.busy), 0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midInReady", int'(bus.in_ready), 1);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("midNoTrail", recvCount - base, 3);
    checkOutput("midBusy", int'(bus.busy), 0);

`ifdef SERIAL_PARITY_EN
    // Parity bit after the LSB of 8'h07
    base = recvCount;
    applyStimulus(8'h07, 8'h07);
    waitIdle();
    checkOutput("parBits", recvCount - base, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
